// File: rtl/p32_pkg.sv
// p32_pkg: shared definitions for the p32 execute stage and its neighbours.
//   - R-type funct codes (FN_*)
//   - exception cause codes (CAUSE_RI, CAUSE_OV), also used by decode
//   - execute-stage state enum and mul/div operation enum
package p32_pkg;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   localparam logic [3:0] CAUSE_RI = 4'hA;
   localparam logic [3:0] CAUSE_OV = 4'hC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } ex_state_t;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_t;

   // Magnitude of a value, treated as signed only when is_signed is set.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      if (is_signed && v[31]) begin
         mag32 = 32'h0 - v;
      end else begin
         mag32 = v;
      end
   endfunction

endpackage

// File: rtl/p32_muldiv_iter.sv
// p32_muldiv_iter: iterative 32x32 multiply / divide, one bit per cycle.
// Ports:
//   m_clock, p_reset : clock, synchronous active-high reset (aborts op)
//   start            : one-cycle request; op/a/b latched in that cycle
//   op               : MULT/MULTU/DIV/DIVU
//   a, b             : operands (multiplicand/multiplier or dividend/divisor)
//   done             : high during the final iteration cycle; hi/lo then
//                      carry the finished result for the caller to capture
//   hi, lo           : result (product, or remainder/quotient)
module p32_muldiv_iter
   import p32_pkg::*;
#(
   parameter int ITER = 32
) (
   input  logic        m_clock,
   input  logic        p_reset,
   input  logic        start,
   input  md_op_t      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

   logic        active_q, active_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] mcand_q, mcand_d;
   logic        is_div_q, is_div_d;
   logic        neg_q, neg_d;
   logic        rneg_q, rneg_d;
   logic        div0_q, div0_d;
   logic [31:0] araw_q, araw_d;

   logic [63:0] step_s;
   logic [32:0] sum_s;
   logic [32:0] rs_s;
   logic        ge_s;
   logic [63:0] prod_s;
   logic        signed_s;
   logic        sa_s, sb_s;
   logic [31:0] ma_s, mb_s;

   // One iteration: shift-add for multiply, restoring step for divide.
   always_comb begin
      sum_s = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'h0);
      rs_s  = {acc_q[63:32], acc_q[31]};
      ge_s  = (rs_s >= {1'b0, mcand_q});
      if (is_div_q) begin
         // Remainder stays below the divisor, so 32-bit subtraction suffices.
         step_s = {(ge_s ? (rs_s[31:0] - mcand_q) : rs_s[31:0]), acc_q[30:0], ge_s};
      end else begin
         step_s = {sum_s, acc_q[31:1]};
      end
   end

   // Result fix-up: signs re-applied, divide-by-zero forced to fixed values.
   always_comb begin
      prod_s = neg_q ? (64'h0 - step_s) : step_s;
      if (is_div_q) begin
         if (div0_q) begin
            lo = 32'hFFFF_FFFF;
            hi = araw_q;
         end else begin
            lo = neg_q  ? (32'h0 - step_s[31:0])  : step_s[31:0];
            hi = rneg_q ? (32'h0 - step_s[63:32]) : step_s[63:32];
         end
      end else begin
         hi = prod_s[63:32];
         lo = prod_s[31:0];
      end
      done = active_q && (cnt_q == LAST_CNT);
   end

   // Next-state: operand capture on start, iterate while active.
   always_comb begin
      signed_s = (op == MD_MULT) || (op == MD_DIV);
      sa_s     = signed_s && a[31];
      sb_s     = signed_s && b[31];
      ma_s     = mag32(a, signed_s);
      mb_s     = mag32(b, signed_s);
      active_d = active_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      div0_d   = div0_q;
      araw_d   = araw_q;
      if (start) begin
         active_d = 1'b1;
         cnt_d    = 6'd0;
         is_div_d = (op == MD_DIV) || (op == MD_DIVU);
         neg_d    = sa_s ^ sb_s;
         rneg_d   = sa_s;
         div0_d   = (b == 32'h0);
         araw_d   = a;
         if ((op == MD_DIV) || (op == MD_DIVU)) begin
            acc_d   = {32'h0, ma_s};
            mcand_d = mb_s;
         end else begin
            acc_d   = {32'h0, mb_s};
            mcand_d = ma_s;
         end
      end else if (active_q) begin
         acc_d = step_s;
         cnt_d = cnt_q + 6'd1;
         if (cnt_q == LAST_CNT) begin
            active_d = 1'b0;
         end else begin
            active_d = 1'b1;
         end
      end else begin
         active_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         active_q <= 1'b0;
         cnt_q    <= 6'd0;
         acc_q    <= 64'h0;
         mcand_q  <= 32'h0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         div0_q   <= 1'b0;
         araw_q   <= 32'h0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         div0_q   <= div0_d;
         araw_q   <= araw_d;
      end
   end

endmodule

// File: rtl/p32_execute_unit.sv
// p32_execute_unit: execute stage of the p32 processor.
// Single-cycle ALU/shift/HI-LO moves; iterative MULT/DIV via p32_muldiv_iter.
// Ports:
//   m_clock, p_reset          : clock, synchronous active-high reset
//   execute                   : operand-valid strobe (ignored while busy)
//   a_in, b_in, shamt_in,
//   funct_in, dest_in         : operands and R-type decode fields
//   busy                      : mul/div in progress
//   write_reg, result,
//   dest_out                  : registered register-file write
//   done                      : mul/div completion pulse
//   hi_out, lo_out            : HI/LO registers
//   exception, cause_out      : squash pulse and cause code
module p32_execute_unit
   import p32_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             m_clock,
   input  logic             p_reset,
   input  logic             execute,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [4:0]       shamt_in,
   input  logic [5:0]       funct_in,
   input  logic [4:0]       dest_in,
   output logic             busy,
   output logic             write_reg,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       dest_out,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             exception,
   output logic [3:0]       cause_out
);

   ex_state_t   state_q, state_d;
   logic        busy_q, busy_d;
   logic        wr_q, wr_d;
   logic [31:0] res_q, res_d;
   logic [4:0]  dest_q, dest_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        exc_q, exc_d;
   logic [3:0]  cause_q, cause_d;

   logic        md_start_s;
   md_op_t      md_op_s;
   logic        md_done_s;
   logic [31:0] md_hi_s, md_lo_s;

   logic [4:0]  sh_s;
   logic [31:0] sum_s, diff_s;
   logic        ov_add_s, ov_sub_s;

   p32_muldiv_iter #(.ITER(ITER)) u_muldiv (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .start   (md_start_s),
      .op      (md_op_s),
      .a       (a_in),
      .b       (b_in),
      .done    (md_done_s),
      .hi      (md_hi_s),
      .lo      (md_lo_s)
   );

   // Adder/subtractor with signed overflow detection and shift-amount select.
   always_comb begin
      sh_s     = funct_in[2] ? a_in[4:0] : shamt_in;
      sum_s    = a_in + b_in;
      diff_s   = a_in - b_in;
      ov_add_s = (a_in[31] == b_in[31]) && (sum_s[31]  != a_in[31]);
      ov_sub_s = (a_in[31] != b_in[31]) && (diff_s[31] != a_in[31]);
   end

   // Decode, FSM next-state and output next-values.
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      wr_d       = 1'b0;
      res_d      = res_q;
      dest_d     = dest_q;
      done_d     = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      exc_d      = 1'b0;
      cause_d    = cause_q;
      md_start_s = 1'b0;
      md_op_s    = MD_MULT;
      case (state_q)
         IDLE: begin
            if (execute) begin
               case (funct_in)
                  FN_SLL, FN_SLLV: begin wr_d = 1'b1; res_d = b_in << sh_s; end
                  FN_SRL, FN_SRLV: begin wr_d = 1'b1; res_d = b_in >> sh_s; end
                  FN_SRA, FN_SRAV: begin wr_d = 1'b1; res_d = $unsigned($signed(b_in) >>> sh_s); end
                  FN_MFHI: begin wr_d = 1'b1; res_d = hi_q; end
                  FN_MFLO: begin wr_d = 1'b1; res_d = lo_q; end
                  FN_MTHI: hi_d = a_in;
                  FN_MTLO: lo_d = a_in;
                  FN_ADD: begin
                     if (ov_add_s) begin
                        exc_d = 1'b1; cause_d = CAUSE_OV;
                     end else begin
                        wr_d = 1'b1; res_d = sum_s;
                     end
                  end
                  FN_SUB: begin
                     if (ov_sub_s) begin
                        exc_d = 1'b1; cause_d = CAUSE_OV;
                     end else begin
                        wr_d = 1'b1; res_d = diff_s;
                     end
                  end
                  FN_ADDU: begin wr_d = 1'b1; res_d = sum_s; end
                  FN_SUBU: begin wr_d = 1'b1; res_d = diff_s; end
                  FN_AND:  begin wr_d = 1'b1; res_d = a_in & b_in; end
                  FN_OR:   begin wr_d = 1'b1; res_d = a_in | b_in; end
                  FN_XOR:  begin wr_d = 1'b1; res_d = a_in ^ b_in; end
                  FN_NOR:  begin wr_d = 1'b1; res_d = ~(a_in | b_in); end
                  FN_SLT:  begin wr_d = 1'b1; res_d = {31'h0, ($signed(a_in) < $signed(b_in))}; end
                  FN_SLTU: begin wr_d = 1'b1; res_d = {31'h0, (a_in < b_in)}; end
                  FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                     md_start_s = 1'b1;
                     md_op_s    = md_op_t'(funct_in[1:0]);
                     busy_d     = 1'b1;
                     state_d    = funct_in[1] ? DIV : MUL;
                  end
                  default: begin exc_d = 1'b1; cause_d = CAUSE_RI; end
               endcase
               if (wr_d) begin
                  dest_d = dest_in;
               end else begin
                  dest_d = dest_q;
               end
            end else begin
               state_d = IDLE;
            end
         end
         MUL, DIV: begin
            // execute is dropped here; only completion is of interest.
            if (md_done_s) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               hi_d    = md_hi_s;
               lo_d    = md_lo_s;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Output and architectural registers with synchronous reset.
   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         wr_q    <= 1'b0;
         res_q   <= 32'h0;
         dest_q  <= 5'd0;
         done_q  <= 1'b0;
         hi_q    <= 32'h0;
         lo_q    <= 32'h0;
         exc_q   <= 1'b0;
         cause_q <= 4'h0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         wr_q    <= wr_d;
         res_q   <= res_d;
         dest_q  <= dest_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         exc_q   <= exc_d;
         cause_q <= cause_d;
      end
   end

   assign busy      = busy_q;
   assign write_reg = wr_q;
   assign result    = res_q;
   assign dest_out  = dest_q;
   assign done      = done_q;
   assign hi_out    = hi_q;
   assign lo_out    = lo_q;
   assign exception = exc_q;
   assign cause_out = cause_q;

endmodule

// File: tb/tb_p32_execute_unit.sv
// Directed self-checking bench for p32_execute_unit.
module tb_p32_execute_unit;
   import p32_pkg::*;

   logic        m_clock;
   logic        p_reset;
   logic        execute;
   logic [31:0] a_in, b_in;
   logic [4:0]  shamt_in;
   logic [5:0]  funct_in;
   logic [4:0]  dest_in;
   logic        busy, write_reg, done, exception;
   logic [31:0] result, hi_out, lo_out;
   logic [4:0]  dest_out;
   logic [3:0]  cause_out;

   int n_cmp = 0;
   int n_err = 0;
   int seen_done;

   p32_execute_unit dut (
      .m_clock   (m_clock),
      .p_reset   (p_reset),
      .execute   (execute),
      .a_in      (a_in),
      .b_in      (b_in),
      .shamt_in  (shamt_in),
      .funct_in  (funct_in),
      .dest_in   (dest_in),
      .busy      (busy),
      .write_reg (write_reg),
      .result    (result),
      .dest_out  (dest_out),
      .done      (done),
      .hi_out    (hi_out),
      .lo_out    (lo_out),
      .exception (exception),
      .cause_out (cause_out)
   );

   initial m_clock = 1'b0;
   always #5 m_clock = ~m_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge m_clock);
      #1;
   endtask

   // Present one op for a single edge; returns in the cycle after acceptance.
   task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [4:0] d);
      funct_in = fn; a_in = a; b_in = b; shamt_in = sh; dest_in = d;
      execute  = 1'b1;
      tick();
      execute  = 1'b0;
   endtask

   // Called in cycle N+1 of a mul/div; checks busy window, ends in cycle N+33.
   task automatic run_md(input string tag);
      int bad_busy = 0;
      for (int k = 1; k <= 32; k++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
         a_in = $urandom; b_in = $urandom;
         tick();
      end
      chk({tag, "_busy_window"}, bad_busy, 32'd0);
      chk({tag, "_done"}, {31'h0, done}, 32'd1);
      chk({tag, "_busy_end"}, {31'h0, busy}, 32'd0);
   endtask

   initial begin
      p_reset = 1'b1; execute = 1'b0;
      a_in = 32'h0; b_in = 32'h0; shamt_in = 5'd0; funct_in = 6'h00; dest_in = 5'd0;
      tick(); tick();
      p_reset = 1'b0;
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_wr", {31'h0, write_reg}, 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_hi", hi_out, 32'h0);
      chk("rst_lo", lo_out, 32'h0);
      chk("rst_exc", {31'h0, exception}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);

      // ADD overflow, then ADDU back-to-back.
      issue(FN_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 5'd3);
      chk("add_ov_exc", {31'h0, exception}, 32'd1);
      chk("add_ov_cause", {28'h0, cause_out}, 32'hC);
      chk("add_ov_wr", {31'h0, write_reg}, 32'd0);
      issue(FN_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 5'd5);
      chk("addu_wr", {31'h0, write_reg}, 32'd1);
      chk("addu_exc", {31'h0, exception}, 32'd0);
      chk("addu_res", result, 32'h8000_0000);
      chk("addu_dest", {27'h0, dest_out}, 32'd5);

      issue(FN_SRA, 32'h0, 32'hF000_0000, 5'd4, 5'd6);
      chk("sra", result, 32'hFF00_0000);
      issue(FN_SRAV, 32'h0000_0024, 32'hF000_0000, 5'd0, 5'd7);
      chk("srav", result, 32'hFF00_0000);
      issue(FN_SRL, 32'h0, 32'hF000_0000, 5'd4, 5'd7);
      chk("srl", result, 32'h0F00_0000);
      issue(FN_SLLV, 32'h0000_0008, 32'h0000_00AB, 5'd1, 5'd7);
      chk("sllv", result, 32'h0000_AB00);
      issue(FN_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 5'd8);
      chk("slt", result, 32'd1);
      issue(FN_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 5'd8);
      chk("sltu", result, 32'd0);
      issue(FN_SUB, 32'h8000_0000, 32'h0000_0001, 5'd0, 5'd9);
      chk("sub_ov_exc", {31'h0, exception}, 32'd1);
      chk("sub_ov_wr", {31'h0, write_reg}, 32'd0);
      issue(FN_NOR, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 5'd9);
      chk("nor", result, 32'hF0F0_FF0F);
      tick();
      chk("idle_wr_deassert", {31'h0, write_reg}, 32'd0);

      // MTHI then MFHI back-to-back.
      issue(FN_MTHI, 32'h1234_5678, 32'h0, 5'd0, 5'd10);
      chk("mthi_wr", {31'h0, write_reg}, 32'd0);
      chk("mthi_hi", hi_out, 32'h1234_5678);
      issue(FN_MFHI, 32'h0, 32'h0, 5'd0, 5'd11);
      chk("mfhi_res", result, 32'h1234_5678);

      issue(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0);
      run_md("multu");
      chk("multu_hi", hi_out, 32'hFFFF_FFFE);
      chk("multu_lo", lo_out, 32'h0000_0001);

      issue(FN_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0);
      run_md("mult");
      chk("mult_hi", hi_out, 32'h0);
      chk("mult_lo", lo_out, 32'h1);

      // DIV -7/2 with an ADD presented during busy.
      issue(FN_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 5'd0, 5'd0);
      for (int k = 1; k <= 32; k++) begin
         if (k == 5) begin
            funct_in = FN_ADD; a_in = 32'h1; b_in = 32'h1; dest_in = 5'd12;
            execute = 1'b1;
         end else begin
            execute = 1'b0;
         end
         tick();
         if (k == 5) begin
            execute = 1'b0;
            chk("div_drop_wr", {31'h0, write_reg}, 32'd0);
            chk("div_drop_exc", {31'h0, exception}, 32'd0);
            chk("div_busy_mid", {31'h0, busy}, 32'd1);
         end
      end
      chk("div_done", {31'h0, done}, 32'd1);
      chk("div_lo", lo_out, 32'hFFFF_FFFD);
      chk("div_hi", hi_out, 32'hFFFF_FFFF);
      issue(FN_MFLO, 32'h0, 32'h0, 5'd0, 5'd13);
      chk("mflo_wr", {31'h0, write_reg}, 32'd1);
      chk("mflo_res", result, 32'hFFFF_FFFD);
      chk("mflo_done_clear", {31'h0, done}, 32'd0);

      issue(FN_DIVU, 32'h0000_0007, 32'h0000_0000, 5'd0, 5'd0);
      run_md("divu0");
      chk("divu0_lo", lo_out, 32'hFFFF_FFFF);
      chk("divu0_hi", hi_out, 32'h0000_0007);

      issue(6'h3F, 32'h1, 32'h2, 5'd0, 5'd14);
      chk("ri_exc", {31'h0, exception}, 32'd1);
      chk("ri_cause", {28'h0, cause_out}, 32'hA);
      chk("ri_wr", {31'h0, write_reg}, 32'd0);
      chk("ri_hi_kept", hi_out, 32'h0000_0007);

      // Reset in the middle of a MULT.
      issue(FN_MULT, 32'h0000_0003, 32'h0000_0005, 5'd0, 5'd0);
      for (int k = 1; k <= 9; k++) tick();
      p_reset = 1'b1;
      tick();
      p_reset = 1'b0;
      chk("abort_busy", {31'h0, busy}, 32'd0);
      chk("abort_hi", hi_out, 32'h0);
      chk("abort_lo", lo_out, 32'h0);
      seen_done = 0;
      for (int k = 0; k < 40; k++) begin
         if (done === 1'b1) seen_done++;
         tick();
      end
      chk("abort_no_done", seen_done, 32'd0);
      issue(FN_ADDU, 32'h0000_0002, 32'h0000_0003, 5'd0, 5'd15);
      chk("abort_then_addu", result, 32'h0000_0005);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/p32_execute_unit.md
# p32_execute_unit

Execute stage of the p32 processor, directly downstream of the decode unit. Accepts operands `a`/`b`, `shamt`, `funct` and destination register from decode, and performs ALU, shift and HI/LO-move operations in one cycle. MULT/MULTU/DIV/DIVU run in 32 iterative cycles on internal HI/LO registers. Produces a registered register-file write strobe plus result, or an exception (overflow / reserved instruction) with cause code.

## Interface
- `WIDTH`, default 32: datapath width; only 32 is supported.
- `ITER`, default 32: mul/div iteration count; must equal `WIDTH`.
- `m_clock`  in  1: clock; all state changes on the rising edge.
- `p_reset`  in  1: synchronous, active-high reset.
- `execute`  in  1: single-cycle strobe; operands are valid in that cycle.
- `a_in`  in  32: rs operand.
- `b_in`  in  32: rt operand.
- `shamt_in`  in  5: immediate shift amount.
- `funct_in`  in  6: R-type function code.
- `dest_in`  in  5: destination register number.
- `busy`  out  1: multiply/divide in progress; the unit ignores `execute` while high.
- `write_reg`  out  1: one-cycle pulse; `result`/`dest_out` are to be written.
- `result`  out  32: write data.
- `dest_out`  out  5: write register number.
- `done`  out  1: one-cycle pulse at mul/div completion.
- `hi_out`, `lo_out`  out  32 each: current HI/LO registers.
- `exception`  out  1: one-cycle pulse; the instruction is squashed.
- `cause_out`  out  4: cause code, valid with `exception`.

## Operation
- States: IDLE, MUL, DIV. Reset puts the unit in IDLE and clears all outputs and HI/LO to 0.
- In IDLE, `execute=1` decodes `funct_in`:
  - Shifts, with result = b shifted: SLL 00, SRL 02, SRA 03 use `shamt_in`; SLLV 04, SRLV 06, SRAV 07 use `a_in[4:0]`.
  - MFHI 10, MFLO 12: result = HI or LO.
  - MTHI 11, MTLO 13: HI or LO <= `a_in`; no `write_reg`.
  - ADD 20, SUB 22: signed. On two's-complement overflow: `exception=1`, `cause_out=4'hC`, no write.
  - ADDU 21, SUBU 23: wrap modulo 2^32, never trap.
  - AND 24, OR 25, XOR 26, NOR 27.
  - SLT 2A (signed) and SLTU 2B: result 1 or 0.
  - MULT 18, MULTU 19: go to MUL. DIV 1A, DIVU 1B: go to DIV. `busy=1` from the next cycle.
  - Any other funct: `exception=1`, `cause_out=4'hA`, no write, HI/LO unchanged.
- MUL: shift-add over 64 bits, one bit per cycle. Signed forms operate on magnitudes and negate the 64-bit product when signs differ. Completion: {HI,LO} <= product.
- DIV: restoring division, one bit per cycle. Signed forms use magnitudes; the quotient sign is a^b and the remainder takes the dividend's sign. Completion: LO <= quotient, HI <= remainder.
- Divide by zero (any signedness): full iteration time, then LO=32'hFFFFFFFF and HI=`a_in`. No exception.
- Mul/div never asserts `write_reg` or `exception`.
- Operands are latched at acceptance. Changes to `a_in`/`b_in` during `busy` have no effect.

## Timing
- Single-cycle ops: accepted at edge N; `write_reg`/`result`/`dest_out`/`exception` are valid during cycle N+1 for exactly one cycle. Outputs deassert in cycle N+2 unless another op was accepted at N+1.
- Back-to-back single-cycle ops are accepted every cycle.
- MTHI/MTLO: the new value is visible on `hi_out`/`lo_out` in cycle N+1. MFHI in cycle N+1 returns the new value.
- Mul/div accepted at edge N: `busy=1` in cycles N+1 .. N+32. `done=1` and HI/LO updated in cycle N+33, with `busy=0` in that cycle. A new `execute` is accepted in cycle N+33.
- `execute` while `busy=1` is dropped silently, with no outputs. Decode/control must stall on `busy`.
- `p_reset` mid-operation aborts the operation. Next cycle: IDLE, `busy=0`, HI=LO=0, and no `done` pulse.
- `exception` and `write_reg` are never high in the same cycle.

## Structure
- Shared package `p32_pkg` holds:
  - funct code constants (`FN_SLL` … `FN_SLTU`);
  - cause constants `CAUSE_RI=4'hA` and `CAUSE_OV=4'hC`, also used by the decode unit;
  - the state enum `ex_state_t`.
- Sub-module `p32_muldiv_iter` holds the iteration counter, 64-bit accumulator and sign fix-up. Its interface is start/op/a/b in and done/hi/lo out. The top level holds the ALU, shifter, HI/LO registers and output registers.

## Test plan
- ADD 7FFFFFFF+00000001 -> N+1: `exception=1`, cause C, `write_reg=0`. ADDU with the same operands -> `result=80000000`, `dest_out` echoed.
- SRA of b=F0000000, shamt 4 -> FF000000. SRAV with a=00000024 -> shift by 4, so also FF000000. SLT FFFFFFFF,00000001 -> 1; SLTU with the same operands -> 0.
- MULTU FFFFFFFF×FFFFFFFF -> `busy` for cycles N+1..N+32, `done` at N+33, HI=FFFFFFFE, LO=00000001. MULT FFFFFFFF×FFFFFFFF -> HI=0, LO=1.
- DIV FFFFFFF9 (−7) / 00000002 -> LO=FFFFFFFD, HI=FFFFFFFF. DIVU 00000007/00000000 -> LO=FFFFFFFF, HI=00000007 at N+33.
- `execute` ADD at N+5 during a DIV -> no output. MFLO at N+33 -> returns the quotient. funct 3F -> exception cause A.
- `p_reset` at N+10 of a MULT -> `busy=0` and HI=LO=0 next cycle, and no `done` pulse ever appears.
